// File: rtl/alu_pkg.sv
// Shared ALU decode definitions: op encodings, RV32I opcodes, stage states and the decoded entry.
package alu_pkg;

  localparam int ALU_XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} stage_state_t;

  typedef struct packed {
    logic [3:0]          alu_control;
    logic                a_is_pc;
    logic                b_is_imm;
    logic [ALU_XLEN-1:0] imm;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [ALU_XLEN-1:0] pc;
    logic                illegal;
  } dec_entry_t;

  function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  alu_from_funct3 = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_funct3 = ALU_SLL;
      3'b010:  alu_from_funct3 = ALU_SLT;
      3'b011:  alu_from_funct3 = ALU_SLTU;
      3'b100:  alu_from_funct3 = ALU_XOR;
      3'b101:  alu_from_funct3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_funct3 = ALU_OR;
      default: alu_from_funct3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I instruction decoder producing one ALU-stage entry.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0]         instr,
  input  logic [ALU_XLEN-1:0] pc,
  output dec_entry_t          entry
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt;
  logic        illegal;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign imm_i     = {{20{instr[31]}}, instr[31:20]};
  assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u     = {instr[31:12], 12'b0};
  assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_shamt = {27'b0, instr[24:20]};

  always_comb begin
    entry             = '0;
    entry.pc          = pc;
    entry.rs1         = instr[19:15];
    entry.rs2         = instr[24:20];
    entry.rd          = instr[11:7];
    entry.alu_control = ALU_ADD;
    illegal           = 1'b0;

    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE || (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))
          entry.alu_control = alu_from_funct3(funct3, funct7 == F7_ALT);
        else
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        entry.b_is_imm = 1'b1;
        case (funct3)
          3'b001: begin
            entry.alu_control = ALU_SLL;
            entry.imm         = imm_shamt;
            illegal           = (funct7 != F7_BASE);
          end
          3'b101: begin
            entry.alu_control = alu_from_funct3(funct3, funct7 == F7_ALT);
            entry.imm         = imm_shamt;
            illegal           = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
          default: begin
            entry.alu_control = alu_from_funct3(funct3, 1'b0);
            entry.imm         = imm_i;
          end
        endcase
      end
      OPC_LOAD: begin
        entry.b_is_imm = 1'b1;
        entry.imm      = imm_i;
      end
      OPC_STORE: begin
        entry.b_is_imm = 1'b1;
        entry.imm      = imm_s;
      end
      OPC_JAL: begin
        entry.a_is_pc  = 1'b1;
        entry.b_is_imm = 1'b1;
        entry.imm      = imm_j;
      end
      OPC_JALR: begin
        entry.a_is_pc  = 1'b1;
        entry.b_is_imm = 1'b1;
        entry.imm      = imm_i;
      end
      OPC_LUI: begin
        entry.b_is_imm = 1'b1;
        entry.imm      = imm_u;
        entry.rs1      = 5'd0;
      end
      OPC_AUIPC: begin
        entry.a_is_pc  = 1'b1;
        entry.b_is_imm = 1'b1;
        entry.imm      = imm_u;
      end
      OPC_BRANCH: begin
        entry.imm = imm_b;
        case (funct3)
          3'b000, 3'b001: entry.alu_control = ALU_SUB;
          3'b100, 3'b101: entry.alu_control = ALU_SLT;
          3'b110, 3'b111: entry.alu_control = ALU_SLTU;
          default:        illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    // Illegal entries still flow downstream but must not steer operands.
    if (illegal) begin
      entry.alu_control = ALU_ADD;
      entry.imm         = '0;
      entry.b_is_imm    = 1'b0;
      entry.a_is_pc     = 1'b0;
      entry.illegal     = 1'b1;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU decode stage with ready/valid handshake and flush.
// Define ALU_DEC_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_control,
  output logic            out_a_is_pc,
  output logic            out_b_is_imm,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  dec_entry_t   dec, out_q;
  stage_state_t state, state_next;
  logic         accept, load_out;
`ifdef ALU_DEC_SKID_EN
  dec_entry_t   skid_q;
  logic         load_skid, out_from_skid, in_ready_q;
`endif

  alu_op_decode u_dec (
    .instr (in_instr),
    .pc    (in_pc),
    .entry (dec)
  );

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_out   = 1'b0;
`ifdef ALU_DEC_SKID_EN
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
`endif
    // Flush overrides every handshake, including a same-cycle accept.
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            load_out   = 1'b1;
            state_next = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept) begin
`ifdef ALU_DEC_SKID_EN
            if (out_ready) begin
              load_out = 1'b1;
            end else begin
              load_skid  = 1'b1;
              state_next = ST_TWO;
            end
`else
            load_out = 1'b1;
`endif
          end else if (out_ready) begin
            state_next = ST_EMPTY;
          end
        end
`ifdef ALU_DEC_SKID_EN
        ST_TWO: begin
          if (out_ready) begin
            out_from_skid = 1'b1;
            state_next    = ST_ONE;
          end
        end
`endif
        default: state_next = ST_EMPTY;
      endcase
    end
  end

`ifdef ALU_DEC_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (load_out)           out_q <= dec;
      else if (out_from_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= dec;
      in_ready_q <= (state_next != ST_TWO);
    end
  end

  assign in_ready = in_ready_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        out_q <= '0;
    else if (load_out) out_q <= dec;
  end

  assign in_ready = (state == ST_EMPTY) || out_ready;
`endif

  assign out_valid       = (state != ST_EMPTY);
  assign out_alu_control = out_q.alu_control;
  assign out_a_is_pc     = out_q.a_is_pc;
  assign out_b_is_imm    = out_q.b_is_imm;
  assign out_imm         = out_q.imm;
  assign out_rs1         = out_q.rs1;
  assign out_rs2         = out_q.rs2;
  assign out_rd          = out_q.rd;
  assign out_pc          = out_q.pc;
  assign out_illegal     = out_q.illegal;

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered decode stage that sits between instruction fetch and the ALU. Accepts one 32-bit RV32I instruction per handshake and emits the ALU operation select (4-bit encoding below), operand-source selects, immediate and register indices one cycle later. Ready/valid on both sides, flush, and optional skid buffering.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address, passed through
- flush  in  1  synchronous discard of all held and incoming entries
- out_valid  out  1  decoded entry present
- out_ready  in  1  consumer accepts
- out_alu_control  out  4  ALU op select
- out_a_is_pc  out  1  operand A = PC (AUIPC, JAL, JALR)
- out_b_is_imm  out  1  operand B = immediate
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J); for shift-immediates, shamt zero-extended
- out_rs1, out_rs2, out_rd  out  5 each  register indices (rs1 forced 0 for LUI)
- out_pc  out  XLEN  passed-through PC
- out_illegal  out  1  unsupported opcode/funct encoding

## Operation
- ALU encoding: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
- OP (0110011), funct3 → op: 000 ADD, or SUB if funct7=0100000; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if funct7=0100000; 110 OR; 111 AND. Any other funct7 (not 0000000/0100000, or 0100000 with funct3 ∉ {000,101}) → illegal.
- OP-IMM (0010011): same map; funct3 000 always ADD. SLLI requires funct7=0000000. SRLI/SRAI require funct7 0000000/0100000. Otherwise illegal.
- LOAD, STORE, JAL, JALR, LUI, AUIPC → ADD. BRANCH: BEQ/BNE → SUB; BLT/BGE → SLT; BLTU/BGEU → SLTU; funct3 010/011 → illegal.
- Illegal entries are still emitted with out_illegal=1, out_alu_control=ADD, and out_imm/out_b_is_imm/out_a_is_pc=0.
- Entries leave in acceptance order. Output fields are stable while out_valid && !out_ready.

## Timing
- Reset: out_valid=0, all data outputs 0, in_ready=1, state EMPTY.
- Latency: 1 cycle from accept (in_valid && in_ready) to out_valid.
- Throughput: 1 per cycle while out_ready=1.
- States (skid build): EMPTY, ONE, TWO.
  - EMPTY --accept--> ONE
  - ONE --accept && !out_ready--> TWO (new entry captured in skid)
  - ONE --accept && out_ready--> ONE (output register reloaded)
  - ONE --!accept && out_ready--> EMPTY
  - TWO --out_ready--> ONE (skid moves to output)
- in_ready = (state != TWO), driven from a register.
- Flush: all states go to EMPTY next cycle; any same-cycle accept is dropped. Flush wins over out_ready.
- rst_n asserted mid-operation: immediate return to reset values; no entry survives.

## Configuration
- ALU_DEC_SKID_EN defined: 2-entry skid as above; in_ready has no combinational path from out_ready.
- Not defined: single output register; states EMPTY/ONE only. in_ready = !out_valid || out_ready (combinational). Flush and latency are unchanged.

## Structure
- Shared package alu_pkg: ALU op localparams (ALU_ADD … ALU_AND), opcode constants (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC), and a decoded-entry packed struct.
- One combinational sub-module, alu_op_decode (instr → decoded entry), instantiated once on the input side. Skid/handshake logic stays in the top module.

## Test plan
- 0x002081B3 (add x3,x1,x2) accepted at cycle N → cycle N+1: out_alu_control=0000, b_is_imm=0, rs1=1, rs2=2, rd=3.
- 0x402081B3 (sub) → 0001. 0x40335293 (srai x5,x6,3) → 0111, b_is_imm=1, out_imm=3, rd=5.
- BLTU (funct3 110) → 0100, out_imm = sign-extended B offset. LUI 0x123452B7 → ADD, rs1=0, out_imm=0x12345000.
- out_ready=0 for 3 cycles with back-to-back valid inputs A,B,C → (skid build) in_ready drops after B, C is held off; after release, outputs are A, B, C in order, with no loss or duplication.
- Flush asserted with in_valid=1 while in ONE → out_valid=0 next cycle; neither entry is emitted.
- 0x00000000 and 0x0000007F → out_illegal=1, out_alu_control=0000. rst_n pulsed low mid-stream → out_valid=0 immediately.
